pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the multi-cycle MIPS core. It holds the architectural PC and computes the next PC from sequential, branch, register, jump, exception and return sources. It also maintains an exception PC (EPC), a halted state and a retired-update counter. It sits between the control unit (which supplies PCWre/PCSrc) and the instruction-memory address port.

## Interface
- ADDR_W, 32: PC/data width; must be ≥ 32. Jump upper bits are taken from pc4[ADDR_W-1:28].
- RESET_VECTOR, 0: PC value after reset.
- EXC_VECTOR, 32'h0000_0180: exception entry address, zero-extended to ADDR_W.
- CNT_W, 32: width of the retired-update counter.
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- PCWre  in  1  commit strobe; the PC updates only on cycles where it is high.
- PCSrc  in  3  next-PC source: 000 seq, 001 branch, 010 reg, 011 jump, 100 halt, 101 eret; 110/111 reserved.
- ExtendImmediate  in  ADDR_W  sign-extended branch offset, in words.
- rsData  in  ADDR_W  register jump target.
- addr  in  26  jump index.
- exc_req  in  1  exception request; level-sampled every cycle.
- curPC  out  ADDR_W  registered current PC.
- pc4  out  ADDR_W  combinational curPC+4.
- EPC  out  ADDR_W  registered exception PC.
- halted  out  1  high while in HALTED.
- addr_err  out  1  one-cycle pulse on a misaligned-target trap.
- retire_cnt  out  CNT_W  count of committed non-exception PC updates.

## Operation
- All arithmetic is modulo 2^ADDR_W.
- Next-PC targets by source:
  - seq = pc4.
  - branch = pc4 + (ExtendImmediate << 2).
  - reg = rsData.
  - jump = {pc4[ADDR_W-1:28], addr, 2'b00}.
  - eret = EPC.
  - halt = curPC; the FSM enters HALTED.
- FSM has two states, RUN and HALTED. Reset enters RUN.
  - RUN → HALTED on PCWre with PCSrc=100.
  - HALTED → RUN only on exc_req.
  - PCWre is ignored while HALTED.
- Priority each cycle: RST > exc_req > PCWre (RUN only) > hold.
- Exception: curPC ← EXC_VECTOR, EPC ← curPC, state ← RUN. retire_cnt does not change.
- Commit (PCWre in RUN): curPC ← target and retire_cnt ← retire_cnt+1.
  - retire_cnt wraps at 2^CNT_W.
  - The halt commit counts as a retired update.
- Reserved PCSrc values commit as seq.
- Reset values: curPC=RESET_VECTOR, EPC=0, halted=0, addr_err=0, retire_cnt=0.
- RST asserted mid-operation, including while HALTED, overrides everything on that edge.

## Timing
- curPC, EPC, halted, retire_cnt and addr_err change only on the CLK rising edge.
- Latency: the target selected in cycle N appears on curPC in cycle N+1.
- pc4 and the internal target are combinational from curPC and the inputs, with zero latency.
- exc_req together with PCWre in the same cycle: the exception wins, the commit is dropped, and EPC takes the pre-edge curPC.
- eret together with exc_req: the exception wins and EPC is overwritten with curPC.
- addr_err is high for exactly the one cycle following a trapping edge.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - A commit whose target has target[1:0] ≠ 0 traps instead of loading.
  - The trap sets curPC ← EXC_VECTOR and EPC ← curPC, pulses addr_err, and does not increment retire_cnt.
  - An external exc_req in the same cycle takes the same path and still pulses addr_err.
- PC_ALIGN_CHECK_EN undefined:
  - The target is loaded verbatim.
  - addr_err is tied to 0.

## Structure
- Package pc_pkg holds:
  - the PCSrc encodings (PC_SEQ, PC_BR, PC_REG, PC_JMP, PC_HALT, PC_ERET);
  - the FSM state enum (ST_RUN, ST_HALTED);
  - the default EXC_VECTOR constant.
- Sub-module next_pc_mux is purely combinational: curPC, EPC and the operands in; pc4 and target out. pc_unit contains the registers, FSM, counter and alignment check.

## Test plan
- Reset, seq and branch: RST=1 for one cycle, then PCWre seq ×3 → curPC = 0, 4, 8, 12 and retire_cnt=3. Then branch with ExtendImmediate=-2 from 12 → curPC=8.
- Jump and reg: from curPC=32'h1000_0000, jump with addr=26'h0000040 → curPC=32'h1000_0100. Then reg with rsData=32'h0040_0020 → 32'h0040_0020.
- Exception collision: from curPC=0x20, drive exc_req and PCWre (branch) in the same cycle → curPC=0x180, EPC=0x20, retire_cnt unchanged. A following eret commit → curPC=0x20.
- Halt: commit halt at curPC=0x40 → halted=1. Further PCWre for 5 cycles leaves curPC=0x40 and retire_cnt unchanged. Then exc_req → curPC=0x180, EPC=0x40, halted=0.
- Alignment: reg with rsData=0x203.
  - With PC_ALIGN_CHECK_EN → curPC=0x180, addr_err high for one cycle, EPC = the prior PC.
  - Without the macro → curPC=0x203 and addr_err=0.
- Wrap: with CNT_W=4, 17 commits → retire_cnt=1. With curPC=32'hFFFF_FFFC, a seq commit → curPC=0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   - PCSrc encodings for the next-PC source select
//   - FSM state enum (ST_RUN, ST_HALTED)
//   - default exception entry address
package pc_pkg;

    localparam logic [2:0] PC_SEQ  = 3'b000;
    localparam logic [2:0] PC_BR   = 3'b001;
    localparam logic [2:0] PC_REG  = 3'b010;
    localparam logic [2:0] PC_JMP  = 3'b011;
    localparam logic [2:0] PC_HALT = 3'b100;
    localparam logic [2:0] PC_ERET = 3'b101;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pc_state_t;

    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0180;

endpackage

// File: rtl/pc_unit_next_pc_mux.sv
// next_pc_mux: purely combinational next-PC target selection.
// Ports:
//   cur_pc   in  ADDR_W  current PC
//   epc      in  ADDR_W  exception PC (eret target)
//   pc_src   in  3       source select (reserved codes behave as seq)
//   ext_imm  in  ADDR_W  sign-extended branch offset in words
//   rs_data  in  ADDR_W  register jump target
//   addr     in  26      jump index
//   pc4      out ADDR_W  cur_pc + 4
//   target   out ADDR_W  selected next PC
module next_pc_mux
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] cur_pc,
    input  logic [ADDR_W-1:0] epc,
    input  logic [2:0]        pc_src,
    input  logic [ADDR_W-1:0] ext_imm,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic [25:0]       addr,
    output logic [ADDR_W-1:0] pc4,
    output logic [ADDR_W-1:0] target
);

    assign pc4 = cur_pc + ADDR_W'(4);

    always_comb begin
        target = pc4;
        case (pc_src)
            PC_SEQ:  target = pc4;
            PC_BR:   target = pc4 + (ext_imm << 2);
            PC_REG:  target = rs_data;
            PC_JMP:  target = {pc4[ADDR_W-1:28], addr, 2'b00};
            PC_HALT: target = cur_pc;
            PC_ERET: target = epc;
            default: target = pc4;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the multi-cycle MIPS core.
// Holds the architectural PC, exception PC, RUN/HALTED state and a
// counter of retired (committed, non-exception) PC updates.
// Optional feature macro: PC_ALIGN_CHECK_EN -- misaligned commit targets
// trap to EXC_VECTOR and pulse addr_err; otherwise targets load verbatim
// and addr_err is tied low.
// Ports:
//   CLK, RST         clock (rising edge), synchronous active-high reset
//   PCWre            commit strobe (ignored while halted)
//   PCSrc            next-PC source select
//   ExtendImmediate  branch offset in words
//   rsData           register jump target
//   addr             jump index
//   exc_req          exception request, sampled every cycle
//   curPC            registered current PC
//   pc4              combinational curPC + 4
//   EPC              registered exception PC
//   halted           high while in ST_HALTED
//   addr_err         one-cycle pulse after a misaligned-target trap
//   retire_cnt       committed non-exception update count (wraps)
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [31:0]       EXC_VECTOR   = DEFAULT_EXC_VECTOR,
    parameter int unsigned       CNT_W        = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PCWre,
    input  logic [2:0]        PCSrc,
    input  logic [ADDR_W-1:0] ExtendImmediate,
    input  logic [ADDR_W-1:0] rsData,
    input  logic [25:0]       addr,
    input  logic              exc_req,
    output logic [ADDR_W-1:0] curPC,
    output logic [ADDR_W-1:0] pc4,
    output logic [ADDR_W-1:0] EPC,
    output logic              halted,
    output logic              addr_err,
    output logic [CNT_W-1:0]  retire_cnt
);

    // Zero-extension: ADDR_W is at least 32.
    localparam logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(EXC_VECTOR);

    pc_state_t         state;
    logic [ADDR_W-1:0] target;
    logic              commit;
    logic              misalign;
    logic              trap;

    next_pc_mux #(
        .ADDR_W (ADDR_W)
    ) u_mux (
        .cur_pc  (curPC),
        .epc     (EPC),
        .pc_src  (PCSrc),
        .ext_imm (ExtendImmediate),
        .rs_data (rsData),
        .addr    (addr),
        .pc4     (pc4),
        .target  (target)
    );

    assign commit = PCWre && (state == ST_RUN);

`ifdef PC_ALIGN_CHECK_EN
    assign misalign = commit && (target[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // An external exception and an alignment trap share the same entry path.
    assign trap   = exc_req || misalign;
    assign halted = (state == ST_HALTED);

    always_ff @(posedge CLK) begin
        if (RST) begin
            curPC      <= RESET_VECTOR;
            EPC        <= '0;
            state      <= ST_RUN;
            retire_cnt <= '0;
        end else if (trap) begin
            curPC <= EXC_VEC;
            EPC   <= curPC;
            state <= ST_RUN;
        end else if (commit) begin
            curPC      <= target;
            retire_cnt <= retire_cnt + CNT_W'(1);
            if (PCSrc == PC_HALT) begin
                state <= ST_HALTED;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Pulses on a misaligned commit even when exc_req arrives alongside it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= misalign;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        PCWre = 1'b0;
    logic [2:0]  PCSrc = 3'b000;
    logic [31:0] ExtendImmediate = '0;
    logic [31:0] rsData = '0;
    logic [25:0] addr = '0;
    logic        exc_req = 1'b0;
    logic [31:0] curPC;
    logic [31:0] pc4;
    logic [31:0] EPC;
    logic        halted;
    logic        addr_err;
    logic [3:0]  retire_cnt;

    pc_unit #(
        .ADDR_W       (32),
        .RESET_VECTOR (32'h0),
        .EXC_VECTOR   (32'h0000_0180),
        .CNT_W        (4)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .PCWre           (PCWre),
        .PCSrc           (PCSrc),
        .ExtendImmediate (ExtendImmediate),
        .rsData          (rsData),
        .addr            (addr),
        .exc_req         (exc_req),
        .curPC           (curPC),
        .pc4             (pc4),
        .EPC             (EPC),
        .halted          (halted),
        .addr_err        (addr_err),
        .retire_cnt      (retire_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] rs;
        logic [25:0] ja;
        logic        exc;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        h;
        logic [3:0]  cnt;
        logic        ae;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        h;
        logic [3:0]  cnt;
        logic        ae;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_pc;
    logic        prev_known = 1'b0;

    localparam logic [31:0] EXC = 32'h0000_0180;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[%0d]: actual=%h required=%h", name, idx, act, req);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic we, input logic [2:0] src,
                                input logic [31:0] imm, input logic [31:0] rs,
                                input logic [25:0] ja, input logic exc,
                                input logic [31:0] pc, input logic [31:0] epc,
                                input logic h, input logic [3:0] cnt, input logic ae);
        vec_t v;
        v.rst = rst; v.we = we; v.src = src; v.imm = imm; v.rs = rs; v.ja = ja;
        v.exc = exc; v.pc = pc; v.epc = epc; v.h = h; v.cnt = cnt; v.ae = ae;
        return v;
    endfunction

    // Drive one cycle on the falling edge, push expectation, compare after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        @(negedge CLK);
        RST = v.rst; PCWre = v.we; PCSrc = v.src; ExtendImmediate = v.imm;
        rsData = v.rs; addr = v.ja; exc_req = v.exc;
        #1;
        if (prev_known) check("pc4", idx, pc4, prev_pc + 32'd4);
        e.pc = v.pc; e.epc = v.epc; e.h = v.h; e.cnt = v.cnt; e.ae = v.ae;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        check("curPC", idx, curPC, got.pc);
        check("EPC", idx, EPC, got.epc);
        check("halted", idx, {31'd0, halted}, {31'd0, got.h});
        check("retire_cnt", idx, {28'd0, retire_cnt}, {28'd0, got.cnt});
        check("addr_err", idx, {31'd0, addr_err}, {31'd0, got.ae});
        prev_pc = got.pc;
        prev_known = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rst we src imm rs ja exc | pc epc h cnt ae
        tbl.push_back(mk(1,0,3'b000,0,0,0,0, 32'h0,0,0,0,0));
        tbl.push_back(mk(0,1,3'b000,0,0,0,0, 32'h4,0,0,1,0));
        tbl.push_back(mk(0,1,3'b000,0,0,0,0, 32'h8,0,0,2,0));
        tbl.push_back(mk(0,1,3'b000,0,0,0,0, 32'hC,0,0,3,0));
        tbl.push_back(mk(0,1,3'b001,32'hFFFF_FFFE,0,0,0, 32'h8,0,0,4,0));
        tbl.push_back(mk(0,1,3'b010,0,32'h1000_0000,0,0, 32'h1000_0000,0,0,5,0));
        tbl.push_back(mk(0,1,3'b011,0,0,26'h0000040,0, 32'h1000_0100,0,0,6,0));
        tbl.push_back(mk(0,1,3'b010,0,32'h0040_0020,0,0, 32'h0040_0020,0,0,7,0));
        tbl.push_back(mk(0,1,3'b010,0,32'h20,0,0, 32'h20,0,0,8,0));
        tbl.push_back(mk(0,1,3'b001,32'd5,0,0,1, EXC,32'h20,0,8,0));
        tbl.push_back(mk(0,1,3'b101,0,0,0,0, 32'h20,32'h20,0,9,0));
        tbl.push_back(mk(0,1,3'b010,0,32'h40,0,0, 32'h40,32'h20,0,10,0));
        tbl.push_back(mk(0,1,3'b100,0,0,0,0, 32'h40,32'h20,1,11,0));
        for (int unsigned i = 0; i < 5; i++)
            tbl.push_back(mk(0,1,3'b000,0,0,0,0, 32'h40,32'h20,1,11,0));
        tbl.push_back(mk(0,0,3'b000,0,0,0,1, EXC,32'h40,0,11,0));
        tbl.push_back(mk(0,1,3'b000,0,0,0,0, 32'h184,32'h40,0,12,0));
        tbl.push_back(mk(0,1,3'b101,0,0,0,1, EXC,32'h184,0,12,0));
        tbl.push_back(mk(0,1,3'b101,0,0,0,0, 32'h184,32'h184,0,13,0));
        if (ALIGN) begin
            tbl.push_back(mk(0,1,3'b010,0,32'h203,0,0, EXC,32'h184,0,13,1));
            tbl.push_back(mk(0,0,3'b000,0,0,0,0, EXC,32'h184,0,13,0));
        end else begin
            tbl.push_back(mk(0,1,3'b010,0,32'h203,0,0, 32'h203,32'h184,0,14,0));
            tbl.push_back(mk(0,0,3'b000,0,0,0,0, 32'h203,32'h184,0,14,0));
        end
        tbl.push_back(mk(1,1,3'b001,32'd3,0,0,1, 32'h0,0,0,0,0));
        tbl.push_back(mk(0,1,3'b100,0,0,0,0, 32'h0,0,1,1,0));
        tbl.push_back(mk(1,1,3'b000,0,0,0,1, 32'h0,0,0,0,0));
        tbl.push_back(mk(0,1,3'b110,0,0,0,0, 32'h4,0,0,1,0));
        tbl.push_back(mk(0,1,3'b111,0,0,0,0, 32'h8,0,0,2,0));
        tbl.push_back(mk(0,1,3'b010,0,32'h203,0,1, EXC,32'h8,0,2,ALIGN));
        tbl.push_back(mk(0,0,3'b000,0,0,0,0, EXC,32'h8,0,2,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Counter and PC wrap: 17 commits from reset with CNT_W=4.
        prev_known = 1'b0;
        apply(mk(1,0,3'b000,0,0,0,0, 32'h0,0,0,0,0), 100);
        apply(mk(0,1,3'b010,0,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC,0,0,1,0), 101);
        for (int k = 1; k <= 16; k++) begin
            logic [31:0] epc_v;
            logic [3:0]  cnt_v;
            epc_v = 32'(k - 1) * 32'd4;
            cnt_v = 4'(k + 1);
            apply(mk(0,1,3'b000,0,0,0,0, epc_v,0,0,cnt_v,0), 101 + k);
        end

        @(negedge CLK);
        PCWre = 1'b0; exc_req = 1'b0; RST = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
